// File: rtl/hyperbus_pkg.sv
// Shared types for the hyperbus transaction arbiter: FSM states, beat counter
// and the captured command layout.
package hyperbus_pkg;

  localparam int unsigned HB_NR_CS       = 2;
  localparam int unsigned HB_BURST_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  typedef logic [HB_BURST_WIDTH-1:0] beat_cnt_t;

  localparam beat_cnt_t BEAT_ONE = {{(HB_BURST_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [31:0]          address;
    logic [HB_NR_CS-1:0]  cs;
    logic                 write;
    beat_cnt_t            burst;
    logic                 address_space;
  } hb_cmd_t;

  // Register writes always carry exactly one data beat, whatever burst says.
  function automatic beat_cnt_t beat_load(input logic write, input logic space,
                                          input beat_cnt_t burst);
    if (write && space) begin
      beat_load = BEAT_ONE;
    end else begin
      beat_load = burst;
    end
  endfunction

endpackage

// File: rtl/hyperbus_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NR_REQ. The pointer itself is owned by the caller.
module hyperbus_rr_arbiter #(
  parameter int unsigned NR_REQ = 2,
  localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic [NR_REQ-1:0] req,
  input  logic              en,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NR_REQ-1:0] gnt,
  output logic [IDX_W-1:0]  idx
);

  logic             found_s;
  int unsigned      cand_s;
  logic [IDX_W-1:0] cand_idx_s;

  // Walk the requesters starting at the pointer and latch the first hit.
  always_comb begin
    gnt        = '0;
    idx        = '0;
    found_s    = 1'b0;
    cand_s     = 32'd0;
    cand_idx_s = '0;
    for (int unsigned i = 32'd0; i < NR_REQ; i++) begin
      cand_s     = (32'(ptr) + i) % NR_REQ;
      cand_idx_s = IDX_W'(cand_s);
      if (en && !found_s && req[cand_idx_s]) begin
        found_s         = 1'b1;
        gnt[cand_idx_s] = 1'b1;
        idx             = cand_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// Shares one hyperbus_phy transaction port and its tx/rx channels between
// NR_REQ requesters; each command is locked until all its beats complete.
module hyperbus_trans_arbiter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NR_REQ      = 2,
  parameter int unsigned NR_CS       = HB_NR_CS,
  parameter int unsigned BURST_WIDTH = HB_BURST_WIDTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NR_REQ-1:0]                     req_valid_i,
  output logic [NR_REQ-1:0]                     req_ready_o,
  input  logic [NR_REQ-1:0][31:0]               req_address_i,
  input  logic [NR_REQ-1:0][NR_CS-1:0]          req_cs_i,
  input  logic [NR_REQ-1:0]                     req_write_i,
  input  logic [NR_REQ-1:0][BURST_WIDTH-1:0]    req_burst_i,
  input  logic [NR_REQ-1:0]                     req_address_space_i,
  input  logic [NR_REQ-1:0]                     req_tx_valid_i,
  output logic [NR_REQ-1:0]                     req_tx_ready_o,
  input  logic [NR_REQ-1:0][15:0]               req_tx_data_i,
  input  logic [NR_REQ-1:0][1:0]                req_tx_strb_i,
  output logic [NR_REQ-1:0]                     req_rx_valid_o,
  input  logic [NR_REQ-1:0]                     req_rx_ready_i,
  output logic [15:0]                           req_rx_data_o,
  output logic                                  trans_valid_o,
  input  logic                                  trans_ready_i,
  output logic [31:0]                           trans_address_o,
  output logic [NR_CS-1:0]                      trans_cs_o,
  output logic                                  trans_write_o,
  output logic [BURST_WIDTH-1:0]                trans_burst_o,
  output logic                                  trans_address_space_o,
  output logic                                  tx_valid_o,
  input  logic                                  tx_ready_i,
  output logic [15:0]                           tx_data_o,
  output logic [1:0]                            tx_strb_o,
  input  logic                                  rx_valid_i,
  output logic                                  rx_ready_o,
  input  logic [15:0]                           rx_data_i,
  output logic [NR_REQ-1:0]                     gnt_o,
  output logic                                  busy_o
);

  localparam int unsigned IDX_W = $clog2(NR_REQ);

  arb_state_e        state_r;
  logic [IDX_W-1:0]  ptr_r;
  logic [IDX_W-1:0]  gidx_r;
  logic [NR_REQ-1:0] gnt_r;
  beat_cnt_t         cnt_r;
  hb_cmd_t           cmd_r;
  logic              busy_r;
  logic              trans_valid_r;

  logic [NR_REQ-1:0] arb_gnt_s;
  logic [IDX_W-1:0]  arb_idx_s;
  logic              idle_s;
  hb_cmd_t           cmd_in_s;
  logic              skip_s;
  beat_cnt_t         load_cnt_s;
  logic              active_s;
  logic              wr_act_s;
  logic              rd_act_s;
  logic              beat_hs_s;
  beat_cnt_t         cnt_next_s;

  assign idle_s = (state_r == IDLE);

  hyperbus_rr_arbiter #(.NR_REQ(NR_REQ)) u_rr (
    .req (req_valid_i),
    .en  (idle_s),
    .ptr (ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s)
  );

  // Select the winning requester's command for capture.
  always_comb begin
    cmd_in_s               = '0;
    cmd_in_s.address       = req_address_i[arb_idx_s];
    cmd_in_s.cs            = req_cs_i[arb_idx_s];
    cmd_in_s.write         = req_write_i[arb_idx_s];
    cmd_in_s.burst         = req_burst_i[arb_idx_s];
    cmd_in_s.address_space = req_address_space_i[arb_idx_s];
  end

  // Zero-length memory bursts are acknowledged but never reach the PHY.
  assign skip_s     = !cmd_in_s.address_space && (cmd_in_s.burst == '0);
  assign load_cnt_s = beat_load(cmd_in_s.write, cmd_in_s.address_space, cmd_in_s.burst);

  // Data paths open only while beats remain, so surplus beats are back-pressured.
  assign active_s = ((state_r == ISSUE) || (state_r == DATA)) && (cnt_r != '0);
  assign wr_act_s = active_s && cmd_r.write;
  assign rd_act_s = active_s && !cmd_r.write;

  assign req_ready_o    = idle_s ? arb_gnt_s : '0;
  assign tx_valid_o     = wr_act_s ? req_tx_valid_i[gidx_r] : 1'b0;
  assign tx_data_o      = wr_act_s ? req_tx_data_i[gidx_r] : 16'h0000;
  assign tx_strb_o      = wr_act_s ? req_tx_strb_i[gidx_r] : 2'b00;
  assign req_tx_ready_o = wr_act_s ? (gnt_r & {NR_REQ{tx_ready_i}}) : '0;
  assign req_rx_valid_o = rd_act_s ? (gnt_r & {NR_REQ{rx_valid_i}}) : '0;
  assign rx_ready_o     = rd_act_s ? req_rx_ready_i[gidx_r] : 1'b0;
  assign req_rx_data_o  = rx_data_i;

  assign beat_hs_s  = (tx_valid_o && tx_ready_i) || (rx_valid_i && rx_ready_o);
  assign cnt_next_s = cnt_r - {{(HB_BURST_WIDTH-1){1'b0}}, beat_hs_s};

  assign trans_valid_o         = trans_valid_r;
  assign trans_address_o       = cmd_r.address;
  assign trans_cs_o            = cmd_r.cs;
  assign trans_write_o         = cmd_r.write;
  assign trans_burst_o         = cmd_r.burst;
  assign trans_address_space_o = cmd_r.address_space;
  assign gnt_o                 = gnt_r;
  assign busy_o                = busy_r;

  // Arbitration FSM: capture in IDLE, issue to PHY, count beats to completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= IDLE;
      ptr_r         <= '0;
      gidx_r        <= '0;
      gnt_r         <= '0;
      cnt_r         <= '0;
      cmd_r         <= '0;
      busy_r        <= 1'b0;
      trans_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|arb_gnt_s) begin
            cmd_r         <= cmd_in_s;
            cnt_r         <= load_cnt_s;
            gidx_r        <= arb_idx_s;
            gnt_r         <= arb_gnt_s;
            ptr_r         <= (arb_idx_s == IDX_W'(NR_REQ - 1)) ? '0 : arb_idx_s + IDX_W'(1);
            trans_valid_r <= !skip_s;
            busy_r        <= 1'b1;
            state_r       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_r <= cnt_next_s;
          if (!trans_valid_r) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
          end else if (trans_ready_i) begin
            trans_valid_r <= 1'b0;
            if (cnt_next_s == '0) begin
              state_r <= IDLE;
              gnt_r   <= '0;
              busy_r  <= 1'b0;
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          cnt_r <= cnt_next_s;
          if (beat_hs_s && (cnt_r == BEAT_ONE)) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          gnt_r         <= '0;
          busy_r        <= 1'b0;
          trans_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Directed self-checking bench for hyperbus_trans_arbiter (two requesters).
module tb_hyperbus_trans_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][31:0] req_address_i;
  logic [1:0][1:0]  req_cs_i;
  logic [1:0]       req_write_i;
  logic [1:0][11:0] req_burst_i;
  logic [1:0]       req_address_space_i;
  logic [1:0]       req_tx_valid_i;
  logic [1:0]       req_tx_ready_o;
  logic [1:0][15:0] req_tx_data_i;
  logic [1:0][1:0]  req_tx_strb_i;
  logic [1:0]       req_rx_valid_o;
  logic [1:0]       req_rx_ready_i;
  logic [15:0]      req_rx_data_o;
  logic             trans_valid_o;
  logic             trans_ready_i;
  logic [31:0]      trans_address_o;
  logic [1:0]       trans_cs_o;
  logic             trans_write_o;
  logic [11:0]      trans_burst_o;
  logic             trans_address_space_o;
  logic             tx_valid_o;
  logic             tx_ready_i;
  logic [15:0]      tx_data_o;
  logic [1:0]       tx_strb_o;
  logic             rx_valid_i;
  logic             rx_ready_o;
  logic [15:0]      rx_data_i;
  logic [1:0]       gnt_o;
  logic             busy_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int trans_hs_cnt = 0;
  int tx_beat_cnt  = 0;
  int rx_beat_cnt  = 0;
  int base_tr;
  int base_tx;
  int base_rx;
  logic [1:0] exp_oh;

  hyperbus_trans_arbiter #(.NR_REQ(2), .NR_CS(2), .BURST_WIDTH(12)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_address_i(req_address_i), .req_cs_i(req_cs_i),
    .req_write_i(req_write_i), .req_burst_i(req_burst_i),
    .req_address_space_i(req_address_space_i),
    .req_tx_valid_i(req_tx_valid_i), .req_tx_ready_o(req_tx_ready_o),
    .req_tx_data_i(req_tx_data_i), .req_tx_strb_i(req_tx_strb_i),
    .req_rx_valid_o(req_rx_valid_o), .req_rx_ready_i(req_rx_ready_i),
    .req_rx_data_o(req_rx_data_o),
    .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i),
    .trans_address_o(trans_address_o), .trans_cs_o(trans_cs_o),
    .trans_write_o(trans_write_o), .trans_burst_o(trans_burst_o),
    .trans_address_space_o(trans_address_space_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_data_o(tx_data_o), .tx_strb_o(tx_strb_o),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Count PHY-side handshakes at each active edge.
  always @(posedge clk_i) begin
    if (trans_valid_o && trans_ready_i) trans_hs_cnt <= trans_hs_cnt + 1;
    if (tx_valid_o && tx_ready_i)       tx_beat_cnt  <= tx_beat_cnt + 1;
    if (rx_valid_i && rx_ready_o)       rx_beat_cnt  <= rx_beat_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid_i = '0; req_address_i = '0; req_cs_i = '0; req_write_i = '0;
    req_burst_i = '0; req_address_space_i = '0; req_tx_valid_i = '0;
    req_tx_data_i = '0; req_tx_strb_i = '0; req_rx_ready_i = '0;
    trans_ready_i = 1'b0; tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 16'h0000;

    // Reset state
    @(negedge clk_i); #1;
    chk("rst_trans_valid", trans_valid_o, 1'b0);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_req_ready", req_ready_o, 2'b00);
    chk("rst_tx_valid", tx_valid_o, 1'b0);
    chk("rst_rx_ready", rx_ready_o, 1'b0);
    @(negedge clk_i); rst_ni = 1'b1;

    // T1: single read from req1, burst 4
    @(negedge clk_i);
    req_valid_i = 2'b10; req_address_i[1] = 32'h1000_0040; req_cs_i[1] = 2'b10;
    req_write_i[1] = 1'b0; req_burst_i[1] = 12'd4; req_address_space_i[1] = 1'b0;
    req_rx_ready_i = 2'b10; trans_ready_i = 1'b1;
    base_tr = trans_hs_cnt; base_rx = rx_beat_cnt;
    #1 chk("t1_req_ready", req_ready_o, 2'b10);
    @(negedge clk_i); req_valid_i = 2'b00;
    #1 chk("t1_gnt", gnt_o, 2'b10);
    chk("t1_trans_valid", trans_valid_o, 1'b1);
    chk("t1_trans_addr", trans_address_o, 32'h1000_0040);
    chk("t1_trans_cs", trans_cs_o, 2'b10);
    chk("t1_trans_burst", trans_burst_o, 12'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); rx_valid_i = 1'b1; rx_data_i = 16'(16'hA000 + k);
      #1 chk("t1_rx_valid_route", req_rx_valid_o, 2'b10);
      chk("t1_rx_data", req_rx_data_o, 16'(16'hA000 + k));
      chk("t1_busy", busy_o, 1'b1);
    end
    @(negedge clk_i);
    #1 chk("t1_busy_drop", busy_o, 1'b0);
    chk("t1_gnt_clear", gnt_o, 2'b00);
    chk("t1_stray_rx_ready", rx_ready_o, 1'b0);
    chk("t1_stray_rx_route", req_rx_valid_o, 2'b00);
    chk("t1_trans_hs", 64'(trans_hs_cnt - base_tr), 64'd1);
    chk("t1_rx_beats", 64'(rx_beat_cnt - base_rx), 64'd4);

    // T2: both requesters writing burst 2 continuously, order 0,1,0,1
    @(negedge clk_i);
    rx_valid_i = 1'b0; req_rx_ready_i = 2'b00;
    req_valid_i = 2'b11; req_write_i = 2'b11; req_burst_i[0] = 12'd2; req_burst_i[1] = 12'd2;
    req_address_space_i = 2'b00; req_tx_valid_i = 2'b11;
    req_tx_data_i[0] = 16'h1110; req_tx_data_i[1] = 16'h2220;
    req_tx_strb_i[0] = 2'b11; req_tx_strb_i[1] = 2'b01;
    tx_ready_i = 1'b1; trans_ready_i = 1'b1; base_tx = tx_beat_cnt;
    for (int t = 0; t < 4; t++) begin
      exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
      if (t != 0) @(negedge clk_i);
      #1 chk("t2_req_ready", req_ready_o, exp_oh);
      @(negedge clk_i);
      #1 chk("t2_gnt", gnt_o, exp_oh);
      chk("t2_tx_data", tx_data_o, (t % 2 == 0) ? 16'h1110 : 16'h2220);
      chk("t2_tx_strb", tx_strb_o, (t % 2 == 0) ? 2'b11 : 2'b01);
      chk("t2_tx_ready_route_a", req_tx_ready_o, exp_oh);
      @(negedge clk_i);
      #1 chk("t2_tx_ready_route_b", req_tx_ready_o, exp_oh);
      chk("t2_trans_valid_low", trans_valid_o, 1'b0);
    end
    @(negedge clk_i); req_valid_i = 2'b00; req_tx_valid_i = 2'b00;
    #1 chk("t2_idle", busy_o, 1'b0);
    chk("t2_tx_beats", 64'(tx_beat_cnt - base_tx), 64'd8);

    // T3: register write, burst 8 -> single beat; PHY accepts late
    @(negedge clk_i);
    req_valid_i = 2'b01; req_write_i[0] = 1'b1; req_address_space_i[0] = 1'b1;
    req_burst_i[0] = 12'd8; req_address_i[0] = 32'h0000_0004; req_tx_valid_i = 2'b01;
    req_tx_data_i[0] = 16'h5A5A; trans_ready_i = 1'b0; base_tx = tx_beat_cnt;
    #1 chk("t3_req_ready", req_ready_o, 2'b01);
    @(negedge clk_i); req_valid_i = 2'b00;
    #1 chk("t3_trans_valid", trans_valid_o, 1'b1);
    chk("t3_trans_space", trans_address_space_o, 1'b1);
    chk("t3_trans_burst", trans_burst_o, 12'd8);
    chk("t3_tx_valid_first", tx_valid_o, 1'b1);
    @(negedge clk_i); trans_ready_i = 1'b1;
    #1 chk("t3_still_issue", trans_valid_o, 1'b1);
    chk("t3_tx_valid_after", tx_valid_o, 1'b0);
    chk("t3_tx_ready_after", req_tx_ready_o, 2'b00);
    @(negedge clk_i);
    #1 chk("t3_idle", busy_o, 1'b0);
    chk("t3_tx_beats", 64'(tx_beat_cnt - base_tx), 64'd1);
    @(negedge clk_i); req_tx_valid_i = 2'b00; req_address_space_i = 2'b00;

    // T4: memory read with burst 0 from req1
    req_valid_i = 2'b10; req_write_i[1] = 1'b0; req_burst_i[1] = 12'd0;
    req_address_space_i[1] = 1'b0; trans_ready_i = 1'b1; base_tr = trans_hs_cnt;
    #1 chk("t4_req_ready", req_ready_o, 2'b10);
    @(negedge clk_i); req_valid_i = 2'b00;
    #1 chk("t4_trans_valid", trans_valid_o, 1'b0);
    chk("t4_gnt", gnt_o, 2'b10);
    @(negedge clk_i);
    #1 chk("t4_idle", busy_o, 1'b0);
    chk("t4_trans_hs", 64'(trans_hs_cnt - base_tr), 64'd0);

    // T5: trans_ready withheld 5 cycles, then rx back-pressure
    @(negedge clk_i);
    req_valid_i = 2'b01; req_write_i[0] = 1'b0; req_address_space_i[0] = 1'b0;
    req_burst_i[0] = 12'd3; req_address_i[0] = 32'hCAFE_0000; req_cs_i[0] = 2'b01;
    trans_ready_i = 1'b0; base_tr = trans_hs_cnt; base_rx = rx_beat_cnt;
    #1 chk("t5_req_ready", req_ready_o, 2'b01);
    @(negedge clk_i);
    req_valid_i = 2'b00; req_address_i[0] = 32'hDEAD_BEEF; req_burst_i[0] = 12'd7; req_cs_i[0] = 2'b10;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk_i);
      #1 chk("t5_trans_valid", trans_valid_o, 1'b1);
      chk("t5_trans_addr", trans_address_o, 32'hCAFE_0000);
      chk("t5_trans_burst", trans_burst_o, 12'd3);
      chk("t5_trans_cs", trans_cs_o, 2'b01);
    end
    @(negedge clk_i); trans_ready_i = 1'b1;
    #1 chk("t5_trans_valid_hs", trans_valid_o, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      trans_ready_i = 1'b0; rx_valid_i = 1'b1; rx_data_i = 16'(16'h0B00 + k);
      req_rx_ready_i = (k < 3) ? 2'b00 : 2'b01;
      #1 chk("t5_rx_ready_mirror", rx_ready_o, (k < 3) ? 1'b0 : 1'b1);
      chk("t5_rx_valid_route", req_rx_valid_o, 2'b01);
      chk("t5_busy", busy_o, 1'b1);
    end
    @(negedge clk_i);
    #1 chk("t5_idle", busy_o, 1'b0);
    chk("t5_rx_ready_idle", rx_ready_o, 1'b0);
    chk("t5_rx_beats", 64'(rx_beat_cnt - base_rx), 64'd3);
    chk("t5_trans_hs", 64'(trans_hs_cnt - base_tr), 64'd1);

    // T6: reset asserted mid-write after 2 of 6 beats
    @(negedge clk_i);
    rx_valid_i = 1'b0; req_rx_ready_i = 2'b00;
    req_valid_i = 2'b10; req_write_i[1] = 1'b1; req_address_space_i[1] = 1'b0;
    req_burst_i[1] = 12'd6; req_tx_valid_i = 2'b10; req_tx_data_i[1] = 16'h6666;
    tx_ready_i = 1'b1; trans_ready_i = 1'b1; base_tx = tx_beat_cnt;
    #1 chk("t6_req_ready", req_ready_o, 2'b10);
    @(negedge clk_i); req_valid_i = 2'b00;
    #1 chk("t6_tx_route_issue", req_tx_ready_o, 2'b10);
    @(negedge clk_i);
    #1 chk("t6_tx_valid_data", tx_valid_o, 1'b1);
    @(negedge clk_i); rst_ni = 1'b0;
    #1 chk("t6_rst_trans_valid", trans_valid_o, 1'b0);
    chk("t6_rst_tx_valid", tx_valid_o, 1'b0);
    chk("t6_rst_tx_ready", req_tx_ready_o, 2'b00);
    chk("t6_rst_gnt", gnt_o, 2'b00);
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_req_ready", req_ready_o, 2'b00);
    chk("t6_tx_beats", 64'(tx_beat_cnt - base_tx), 64'd2);
    @(negedge clk_i);
    rst_ni = 1'b1; req_valid_i = 2'b11; req_write_i[0] = 1'b1; req_burst_i[0] = 12'd2;
    req_address_space_i[0] = 1'b0; req_tx_valid_i = 2'b00;
    #1 chk("t6_fresh_req_ready", req_ready_o, 2'b01);
    @(negedge clk_i); req_valid_i = 2'b00;
    #1 chk("t6_fresh_gnt", gnt_o, 2'b01);
    chk("t6_fresh_trans_valid", trans_valid_o, 1'b1);
    chk("t6_fresh_busy", busy_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hyperbus_trans_arbiter.md
Name: hyperbus_trans_arbiter

Overview:
- Shares one hyperbus_phy transaction port, and its tx/rx data channels, between NR_REQ requesters, e.g. the AXI read path, the AXI write path and the register-config path.
- Requesters are served round-robin.
- Each granted command is captured, issued to the PHY, and locked until all of its data beats have handshaken.
- Sits between the AXI front-end and hyperbus_phy in the clk_i domain.

Parameters:
- NR_REQ, 2, number of requesters (≥2).
- NR_CS, 2, number of chip selects, matching the PHY.
- BURST_WIDTH, 12, width of the burst-length field in 16-bit beats.

Ports:
- clk_i  in  1  system clock (same clock as the PHY's clk_i).
- rst_ni  in  1  reset. Asynchronous and active-low: one clock, asynchronous active-low reset.
- req_valid_i  in  NR_REQ  per-requester command valid.
- req_ready_o  out  NR_REQ  per-requester command accept; one-hot or zero.
- req_address_i  in  NR_REQ×32  command address.
- req_cs_i  in  NR_REQ×NR_CS  one-hot chip select.
- req_write_i  in  NR_REQ  1 = write.
- req_burst_i  in  NR_REQ×BURST_WIDTH  beats in the transaction.
- req_address_space_i  in  NR_REQ  1 = register space.
- req_tx_valid_i  in  NR_REQ  write-beat valid.
- req_tx_ready_o  out  NR_REQ  write-beat ready.
- req_tx_data_i  in  NR_REQ×16  write data.
- req_tx_strb_i  in  NR_REQ×2  write byte strobes.
- req_rx_valid_o  out  NR_REQ  read-beat valid.
- req_rx_ready_i  in  NR_REQ  read-beat ready.
- req_rx_data_o  out  16  read data, broadcast to all requesters.
- trans_valid_o  out  1  to PHY.
- trans_ready_i  in  1  from PHY.
- trans_address_o  out  32  to PHY.
- trans_cs_o  out  NR_CS  to PHY.
- trans_write_o  out  1  to PHY.
- trans_burst_o  out  BURST_WIDTH  to PHY.
- trans_address_space_o  out  1  to PHY.
- tx_valid_o  out  1  to PHY.
- tx_ready_i  in  1  from PHY.
- tx_data_o  out  16  to PHY.
- tx_strb_o  out  2  to PHY.
- rx_valid_i  in  1  from PHY.
- rx_ready_o  out  1  to PHY.
- rx_data_i  in  16  from PHY.
- gnt_o  out  NR_REQ  one-hot owner of the current transaction.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - state IDLE; round-robin pointer 0; beat counter 0; captured command all zero.
  - All outputs 0: trans_*, tx_*, req_*_ready_o, req_rx_valid_o, gnt_o, busy_o.
- States are IDLE, ISSUE and DATA.
- IDLE:
  - Grant the first asserted req_valid_i at or after the pointer, wrapping modulo NR_REQ.
  - req_ready_o[g] is high combinationally in that same cycle.
  - Capture the command, set gnt_o to one-hot g, and set pointer = (g+1) mod NR_REQ.
  - Next state is ISSUE.
  - If no requester is valid: stay in IDLE, pointer unchanged.
- Beat count loaded at capture:
  - 1 if write and address_space are both set (register write is always a single beat).
  - Otherwise req_burst_i.
- burst = 0 on a memory access:
  - Accepted, but never issued to the PHY.
  - Pointer still advances; return to IDLE next cycle.
  - trans_valid_o stays 0.
- ISSUE:
  - trans_valid_o = 1 with the captured fields held stable.
  - On trans_valid_o and trans_ready_i both high, go to DATA. Issue latency from grant is 1 cycle minimum.
- Data routing in ISSUE and DATA, for the granted index g only:
  - Write: tx_valid_o = req_tx_valid_i[g]; tx_data_o/tx_strb_o come from g; req_tx_ready_o[g] = tx_ready_i.
  - Read: req_rx_valid_o[g] = rx_valid_i; rx_ready_o = req_rx_ready_i[g].
  - Non-granted ready/valid outputs are 0.
  - The tx path is inactive for reads, and the rx path is inactive for writes.
- Beat counter:
  - Decrements on each handshake of the active channel.
  - A handshake with counter == 1 returns to IDLE next cycle; gnt_o then clears.
  - A data handshake in ISSUE, before trans_ready_i, is counted normally.
  - If the last beat completes while still in ISSUE, stay in ISSUE until trans_ready_i, then go straight to IDLE.
- Outside ISSUE/DATA: rx_ready_o = 0 and tx_valid_o = 0. A stray PHY rx beat is back-pressured, not dropped.
- Requester behaviour after grant: a requester dropping req_valid_i after grant has no effect, because the command is captured.
- No new grant until return to IDLE. Minimum gap between transactions is 1 cycle.
- Asserting rst_ni low mid-transaction aborts immediately to the reset values. The PHY is reset by the same rst_ni.
- Counter width is BURST_WIDTH; no wrap is possible because the counter never decrements from 0.

Decomposition:
- Package hyperbus_pkg holds:
  - the arbiter state enum (IDLE, ISSUE, DATA);
  - the beat-count typedef (logic [BURST_WIDTH-1:0]);
  - a command struct (address, cs, write, burst, address_space).
- Sub-module hyperbus_rr_arbiter, parameterised on NR_REQ:
  - Inputs: req vector, enable, pointer.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single read, req1, burst 4, PHY returns 4 rx beats → exactly one trans handshake, 4 rx beats to req1 only, busy_o drops the cycle after beat 4.
- Both requesters valid continuously, each with write burst 2 → grant order 0,1,0,1; pointer alternates; no tx beat is ever routed to the non-granted requester.
- Register write (address_space=1, write=1, burst=8) → exactly 1 tx beat forwarded, then IDLE; further req_tx_valid_i is ignored.
- Memory read with burst = 0 → req_ready_o pulses, trans_valid_o never rises, back in IDLE after 1 cycle.
- trans_ready_i withheld 5 cycles, then rx back-pressure via req_rx_ready_i low for 3 cycles → trans fields are stable throughout, rx_ready_o mirrors req_rx_ready_i, beat count is correct.
- rst_ni asserted mid-write after 2 of 6 beats → all outputs 0 immediately; after release, req0 wins first with a fresh transaction.
